hazard_tracker: RTL and testbench

//  Consumes the ID-stage decode hazard fields (rs1use, rs2use, hazard_optype, rd/rs1/rs2) from the

---
 rtl/hazard_tracker.sv | 127 ++++++++++++
 tb/tb_hazard_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Hazard tracker for the 5-stage core: follows in-flight producers through EX/MEM/WB and
// derives load-use stalls, IF/ID flush, ID operand forward selects and store-data forwarding.
module hazard_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [1:0]        hazard_optype_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              Branch_ID,
    output logic              stall_PC,
    output logic              stall_FD,
    output logic              bubble_DE,
    output logic              flush_FD,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    logic [1:0]        ex_op, mem_op, wb_op;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [REG_AW-1:0] ex_rs2, mem_rs2;
    logic [CNT_W-1:0]  cnt_q;

    logic              stall;
    logic [1:0]        fwd_a, fwd_b;
    logic              fwd_ls;

    function automatic logic is_producer(input logic [1:0] op, input logic [REG_AW-1:0] rd);
        return ((op == OP_ALU) || (op == OP_LOAD)) && (rd != '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Nearest producer wins; a load still in EX cannot be forwarded, the stall covers it.
    function automatic logic [1:0] fwd_sel(
        input logic              use_src,
        input logic [REG_AW-1:0] rs,
        input logic [1:0]        e_op,
        input logic [REG_AW-1:0] e_rd,
        input logic [1:0]        m_op,
        input logic [REG_AW-1:0] m_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && (rs != '0)) begin
            if (is_producer(e_op, e_rd) && (e_rd == rs))
                sel = (e_op == OP_ALU) ? FWD_EX_ALU : FWD_RF;
            else if (is_producer(m_op, m_rd) && (m_rd == rs))
                sel = (m_op == OP_ALU) ? FWD_MEM_ALU : FWD_MEM_LD;
        end
        return sel;
    endfunction

    always_comb begin
        stall = (ex_op == OP_LOAD) && is_producer(ex_op, ex_rd) &&
                ((rs1use_ID && (rs1_ID == ex_rd)) ||
                 (rs2use_ID && (rs2_ID == ex_rd) && (hazard_optype_ID != OP_STORE)));
        fwd_a  = fwd_sel(rs1use_ID, rs1_ID, ex_op, ex_rd, mem_op, mem_rd);
        fwd_b  = fwd_sel(rs2use_ID, rs2_ID, ex_op, ex_rd, mem_op, mem_rd);
        fwd_ls = (mem_op == OP_STORE) && (mem_rs2 != '0) &&
                 (wb_op == OP_LOAD) && is_producer(wb_op, wb_rd) && (wb_rd == mem_rs2);
    end

    // Stage boundary: ID -> EX -> MEM -> WB, frozen while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op   <= OP_NONE;
            ex_rd   <= '0;
            ex_rs2  <= '0;
            mem_op  <= OP_NONE;
            mem_rd  <= '0;
            mem_rs2 <= '0;
            wb_op   <= OP_NONE;
            wb_rd   <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            if (stall) begin
                ex_op  <= OP_NONE;
                ex_rd  <= '0;
                ex_rs2 <= '0;
                cnt_q  <= sat_inc(cnt_q);
            end else begin
                ex_op  <= hazard_optype_ID;
                ex_rd  <= rd_ID;
                ex_rs2 <= rs2_ID;
            end
            mem_op  <= ex_op;
            mem_rd  <= ex_rd;
            mem_rs2 <= ex_rs2;
            wb_op   <= mem_op;
            wb_rd   <= mem_rd;
        end
    end

    // A taken redirect waits behind a stall so it is retried with valid operands.
    always_comb begin
        stall_PC        = stall & ~rst;
        stall_FD        = stall & ~rst;
        bubble_DE       = stall & ~rst;
        flush_FD        = Branch_ID & ~stall & ~rst;
        forward_ctrl_A  = rst ? FWD_RF : fwd_a;
        forward_ctrl_B  = rst ? FWD_RF : fwd_b;
        forward_ctrl_ls = fwd_ls & ~rst;
        stall_cnt       = rst ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed scenarios plus randomized traffic against an
// instruction-history reference model.
module tb_hazard_tracker;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              rs1use_ID, rs2use_ID;
    logic [1:0]        hazard_optype_ID;
    logic [REG_AW-1:0] rd_ID, rs1_ID, rs2_ID;
    logic              Branch_ID;
    logic              stall_PC, stall_FD, bubble_DE, flush_FD;
    logic [1:0]        forward_ctrl_A, forward_ctrl_B;
    logic              forward_ctrl_ls;
    logic [CNT_W-1:0]  stall_cnt;

    hazard_tracker #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .hazard_optype_ID(hazard_optype_ID),
        .rd_ID(rd_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .Branch_ID(Branch_ID),
        .stall_PC(stall_PC), .stall_FD(stall_FD), .bubble_DE(bubble_DE),
        .flush_FD(flush_FD),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] rd;
        logic [4:0] rs2;
    } instr_t;

    // hist[0] is the youngest issued instruction (in EX), hist[2] the oldest (in WB)
    instr_t hist[$];
    int     m_cnt;
    int     passed = 0;
    int     total  = 0;

    function automatic bit writes_reg(instr_t i);
        return ((i.op == 2'b01) || (i.op == 2'b10)) && (i.rd != 0);
    endfunction

    function automatic bit m_stall();
        if (rst) return 1'b0;
        return (hist[0].op == 2'b10) && writes_reg(hist[0]) &&
               ((rs1use_ID && rs1_ID == hist[0].rd) ||
                (rs2use_ID && rs2_ID == hist[0].rd && hazard_optype_ID != 2'b11));
    endfunction

    function automatic logic [1:0] m_fwd(bit use_src, logic [4:0] rs);
        if (rst || !use_src || rs == 0) return 2'd0;
        if (writes_reg(hist[0]) && hist[0].rd == rs) return (hist[0].op == 2'b01) ? 2'd1 : 2'd0;
        if (writes_reg(hist[1]) && hist[1].rd == rs) return (hist[1].op == 2'b01) ? 2'd2 : 2'd3;
        return 2'd0;
    endfunction

    function automatic bit m_ls();
        if (rst) return 1'b0;
        return (hist[1].op == 2'b11) && (hist[1].rs2 != 0) && (hist[2].op == 2'b10) &&
               writes_reg(hist[2]) && (hist[2].rd == hist[1].rs2);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        instr_t z;
        z = '0;
        hist = {z, z, z};
        m_cnt = 0;
    endtask

    task automatic drive(bit r, bit e, bit r1u, bit r2u, logic [1:0] op,
                         logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, bit br);
        rst = r; en = e; rs1use_ID = r1u; rs2use_ID = r2u; hazard_optype_ID = op;
        rd_ID = rd; rs1_ID = rs1; rs2_ID = rs2; Branch_ID = br;
        #2;
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic tick();
        bit         st;
        logic [9:0] exp_v, obs_v;
        instr_t     nxt;
        if (rst) model_clear();
        st    = m_stall();
        exp_v = {st, st, st, Branch_ID & ~st & ~rst,
                 m_fwd(rs1use_ID, rs1_ID), m_fwd(rs2use_ID, rs2_ID), m_ls()};
        obs_v = {stall_PC, stall_FD, bubble_DE, flush_FD,
                 forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
        check("outputs", 32'(obs_v), 32'(exp_v));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        nxt = st ? instr_t'('0) : instr_t'({hazard_optype_ID, rd_ID, rs2_ID});
        @(posedge clk);
        #1;
        if (rst) model_clear();
        else if (en) begin
            hist.push_front(nxt);
            void'(hist.pop_back());
            if (st && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    initial begin
        model_clear();
        // reset state
        drive(1, 1, 1, 1, 2'b01, 5, 5, 5, 1);
        check("reset_flush", 32'(flush_FD), 32'd0);
        tick();
        // ALU forwarding from EX, then from MEM
        drive(0, 1, 0, 0, 2'b01, 5, 0, 0, 0); tick();
        drive(0, 1, 1, 1, 2'b01, 6, 5, 7, 0);
        check("alu_ex_fwdA", 32'(forward_ctrl_A), 32'd1);
        check("alu_ex_nostall", 32'(stall_PC), 32'd0);
        tick();
        drive(0, 1, 1, 0, 2'b01, 8, 5, 0, 0);
        check("alu_mem_fwdA", 32'(forward_ctrl_A), 32'd2);
        tick();
        // load-use: one stall, then load data from MEM
        drive(0, 1, 0, 0, 2'b10, 5, 0, 0, 0); tick();
        drive(0, 1, 1, 1, 2'b01, 6, 5, 0, 0);
        check("lu_stall", 32'({stall_PC, stall_FD, bubble_DE}), 32'd7);
        tick();
        drive(0, 1, 1, 1, 2'b01, 6, 5, 0, 0);
        check("lu_release", 32'(stall_PC), 32'd0);
        check("lu_fwdA", 32'(forward_ctrl_A), 32'd3);
        tick();
        // store after load: no stall, late store-data forward
        drive(0, 1, 0, 0, 2'b10, 5, 0, 0, 0); tick();
        drive(0, 1, 1, 1, 2'b11, 0, 1, 5, 0);
        check("st_nostall", 32'(stall_PC), 32'd0);
        check("st_fwdB", 32'(forward_ctrl_B), 32'd0);
        tick();
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        check("st_ls", 32'(forward_ctrl_ls), 32'd1);
        tick();
        // x0 producer and store rd field never forward
        drive(0, 1, 0, 0, 2'b01, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 2'b11, 9, 0, 9, 0);
        check("x0_fwdA", 32'(forward_ctrl_A), 32'd0);
        tick();
        drive(0, 1, 1, 0, 2'b01, 3, 9, 0, 0);
        check("store_rd_fwdA", 32'(forward_ctrl_A), 32'd0);
        check("store_rd_nostall", 32'(stall_PC), 32'd0);
        tick();
        // branch during stall is deferred
        drive(0, 1, 0, 0, 2'b10, 5, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 2'b01, 6, 5, 0, 1);
        check("br_stall_flush", 32'(flush_FD), 32'd0);
        tick();
        drive(0, 1, 1, 0, 2'b01, 6, 5, 0, 1);
        check("br_retry_flush", 32'(flush_FD), 32'd1);
        tick();
        // en=0 freezes the pipeline
        drive(0, 1, 0, 0, 2'b10, 7, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 2'b01, 4, 7, 0, 0);
        check("en_hold_stall", 32'(stall_PC), 32'd1);
        tick();
        // counter saturation with back-to-back dependent loads
        for (int i = 0; i < 140; i++) begin
            drive(0, 1, 1, 0, 2'b10, 5, 5, 0, 0);
            tick();
        end
        check("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
        // async reset in the middle of a stall
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 2'b10, 5, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 2'b01, 6, 5, 0, 1);
        check("pre_rst_stall", 32'(stall_PC), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_outputs", 32'({stall_PC, stall_FD, bubble_DE, flush_FD, forward_ctrl_A,
                                  forward_ctrl_B, forward_ctrl_ls}), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        tick();
        drive(0, 1, 1, 0, 2'b01, 6, 5, 0, 0);
        check("post_rst_nostall", 32'(stall_PC), 32'd0);
        tick();
        // randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0,
                  1'($urandom), 1'($urandom), 2'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
